// File: rtl/gate_sweep_ctrl.sv
// Stimulus/check engine for combinational gate blocks.
// Sweeps every input vector in order and scores the responses against a golden table.
module gate_sweep_ctrl #(
  parameter int IN_W   = 2,
  parameter int OUT_W  = 1,
  parameter int SETTLE = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        abort,
  output logic [IN_W-1:0]             dut_in,
  input  logic [OUT_W-1:0]            dut_out,
  input  logic [(2**IN_W)*OUT_W-1:0]  expect_table,
  output logic                        busy,
  output logic                        done,
  output logic                        pass,
  output logic [IN_W:0]               err_count,
  output logic                        first_err_valid,
  output logic [IN_W-1:0]             first_err_vec
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [7:0]      RELOAD   = 8'(SETTLE - 1);
  localparam logic [IN_W-1:0] IDX_LAST = '1;
  localparam logic [IN_W-1:0] IDX_ONE  = 1;
  localparam logic [IN_W:0]   ERR_ONE  = 1;

  state_t          state, state_d;
  logic [IN_W-1:0] idx, idx_d;
  logic [7:0]      cnt, cnt_d;
  logic [IN_W:0]   err, err_d;
  logic            fv, fv_d;
  logic [IN_W-1:0] fvec, fvec_d;
  logic [OUT_W-1:0] exp_val;
  logic            miss;

  assign exp_val = expect_table[idx*OUT_W +: OUT_W];
  // X/Z on the DUT response must score as a failure
  assign miss    = (dut_out !== exp_val);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cnt   <= '0;
      err   <= '0;
      fv    <= 1'b0;
      fvec  <= '0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      cnt   <= cnt_d;
      err   <= err_d;
      fv    <= fv_d;
      fvec  <= fvec_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    err_d   = err;
    fv_d    = fv;
    fvec_d  = fvec;
    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_d = WAIT;
          idx_d   = '0;
          cnt_d   = RELOAD;
          err_d   = '0;
          fv_d    = 1'b0;
          fvec_d  = '0;
        end
      end
      WAIT: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else if (cnt == 8'd0) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt - 8'd1;
        end
      end
      SAMPLE: begin
        if (abort) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          if (miss) begin
            err_d = err + ERR_ONE;
            if (!fv) begin
              fv_d   = 1'b1;
              fvec_d = idx;
            end
          end
          if (idx == IDX_LAST) begin
            state_d = DONE;
          end else begin
            state_d = WAIT;
            idx_d   = idx + IDX_ONE;
            cnt_d   = RELOAD;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign dut_in          = idx;
  assign busy            = (state == WAIT) || (state == SAMPLE);
  assign done            = (state == DONE);
  assign pass            = done && (err == '0);
  assign err_count       = err;
  assign first_err_valid = fv;
  assign first_err_vec   = fvec;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Randomized bench for gate_sweep_ctrl.
// A response table plays the gate; results are predicted from table contents and cycle counts.
module tb_gate_sweep_ctrl;

  localparam int IN_W   = 3;
  localparam int OUT_W  = 2;
  localparam int SETTLE = 2;
  localparam int N      = 2**IN_W;
  localparam int PER    = SETTLE + 1;
  localparam int LEN    = N * PER;

  logic                 clk = 1'b0;
  logic                 reset, start, abort;
  logic [IN_W-1:0]      dut_in;
  logic [OUT_W-1:0]     dut_out;
  logic [N*OUT_W-1:0]   expect_table;
  logic                 busy, done, pass;
  logic [IN_W:0]        err_count;
  logic                 first_err_valid;
  logic [IN_W-1:0]      first_err_vec;

  logic [OUT_W-1:0] resp   [N];
  logic [OUT_W-1:0] golden [N];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign dut_out = resp[dut_in];

  gate_sweep_ctrl #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SETTLE(SETTLE)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .dut_in(dut_in), .dut_out(dut_out), .expect_table(expect_table),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_err_valid(first_err_valid), .first_err_vec(first_err_vec)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  function automatic int exp_errs(input int nvec);
    int e = 0;
    for (int i = 0; i < nvec; i++)
      if (resp[i] !== golden[i]) e++;
    return e;
  endfunction

  function automatic int exp_first(input int nvec);
    for (int i = 0; i < nvec; i++)
      if (resp[i] !== golden[i]) return i;
    return -1;
  endfunction

  task automatic load_table();
    for (int i = 0; i < N; i++)
      expect_table[i*OUT_W +: OUT_W] = golden[i];
  endtask

  task automatic randomize_case();
    int mode = $urandom_range(0, 3);
    for (int i = 0; i < N; i++) begin
      golden[i] = OUT_W'($urandom);
      unique case (mode)
        0: resp[i] = golden[i];
        1: resp[i] = ~golden[i];
        2: resp[i] = ($urandom_range(0, 2) == 0) ? ~golden[i] : golden[i];
        default: resp[i] = ($urandom_range(0, 3) == 0) ? 'x : golden[i];
      endcase
    end
    load_table();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_err"}, err_count, 0);
    check({tag, "_fv"}, first_err_valid, 0);
    check({tag, "_fvec"}, first_err_vec, 0);
    check({tag, "_din"}, dut_in, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_pass"}, pass, 0);
  endtask

  task automatic check_results(input string tag, input int nvec,
                               input bit fin);
    int e = exp_errs(nvec);
    int f = exp_first(nvec);
    check({tag, "_err"}, err_count, e);
    check({tag, "_fv"}, first_err_valid, f >= 0);
    check({tag, "_fvec"}, first_err_vec, (f >= 0) ? f : 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, fin);
    check({tag, "_pass"}, pass, fin && (e == 0));
  endtask

  // cut >= 0: abort (or reset) is held during period cut after the start edge
  task automatic run_sweep(input int cut, input bit use_reset,
                           input bit poke);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < LEN; j++) begin
      check("din", dut_in, j / PER);
      check("busy", busy, 1);
      check("done_early", done, 0);
      if (j == 0) begin
        check("clr_err", err_count, 0);
        check("clr_fv", first_err_valid, 0);
      end
      start = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      if (j == cut) begin
        if (use_reset) reset = 1'b1;
        else abort = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        abort = 1'b0;
        start = 1'b0;
        if (use_reset) begin
          check_zero("rst_mid");
        end else begin
          check_results("abort", j / PER, 0);
          check("abort_din", dut_in, 0);
        end
        return;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check_results("sweep", N, 1);
    check("last_din", dut_in, N - 1);
    repeat ($urandom_range(1, 3)) begin
      abort = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    abort = 1'b0;
    check_results("hold", N, 1);
    check("hold_din", dut_in, N - 1);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    for (int i = 0; i < N; i++) begin
      golden[i] = '0;
      resp[i]   = '0;
    end
    load_table();
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check_zero("idle");

    // all-pass, then all-fail, then same table re-run from DONE
    for (int i = 0; i < N; i++) begin
      golden[i] = OUT_W'(i * 3 + 1);
      resp[i]   = golden[i];
    end
    load_table();
    run_sweep(-1, 0, 0);
    for (int i = 0; i < N; i++) resp[i] = ~golden[i];
    run_sweep(-1, 0, 1);
    run_sweep(-1, 0, 0);

    // abort during vector 2 WAIT, mismatches on 1 and 3
    for (int i = 0; i < N; i++) resp[i] = golden[i];
    resp[1] = ~golden[1];
    resp[3] = ~golden[3];
    run_sweep(2 * PER, 0, 1);

    // reset in SAMPLE of vector 1 with a pending mismatch
    run_sweep(PER + SETTLE, 1, 0);

    for (int t = 0; t < 40; t++) begin
      randomize_case();
      run_sweep(($urandom_range(0, 2) == 0) ? $urandom_range(0, LEN - 1) : -1,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gate_sweep_ctrl.md
Name: gate_sweep_ctrl

Overview:
Self-checking sequencer for combinational gate-level blocks (Nand, And, Mux, ...). On `start` it drives a device-under-test input bus through all 2^IN_W binary combinations in ascending order, waits a settle interval, and samples the DUT output against a packed golden truth table. It reports a mismatch count, the first failing vector and a pass flag. It replaces hand-timed `always #N` stimulus in gate benches and can be reused by higher-level benches as the stimulus/check engine.

Parameters:
IN_W, 2, DUT input width; vectors 0 .. 2^IN_W-1.
OUT_W, 1, DUT output width.
SETTLE, 1, cycles dut_in is held before sampling; legal range 1..255.

Ports:
clk  in  1  rising-edge clock.
reset  in  1  synchronous, active-high reset.
start  in  1  begin sweep; honoured in IDLE or DONE only.
abort  in  1  cancel sweep; honoured in WAIT or SAMPLE.
dut_in  out  IN_W  vector applied to DUT; equals current index.
dut_out  in  OUT_W  DUT response.
expect_table  in  (2^IN_W)*OUT_W  golden table; the expected value for vector i is bits [i*OUT_W +: OUT_W]; must be stable while busy.
busy  out  1  high in WAIT/SAMPLE.
done  out  1  high in DONE.
pass  out  1  done && err_count==0.
err_count  out  IN_W+1  number of mismatching vectors in the last/current sweep.
first_err_valid  out  1  at least one mismatch recorded this sweep.
first_err_vec  out  IN_W  index of the first mismatch.

Behaviour:
- States: IDLE, WAIT, SAMPLE, DONE. All outputs are registered or decoded from registered state.
- Reset (any state, including mid-sweep):
  - state=IDLE, idx=0, dut_in=0, settle counter=0.
  - err_count=0, first_err_valid=0, first_err_vec=0.
  - busy=done=pass=0.
- IDLE or DONE, start=1:
  - next state WAIT; idx=0; settle counter=SETTLE-1.
  - err_count, first_err_valid and first_err_vec cleared.
- WAIT:
  - dut_in=idx held constant.
  - If counter==0, go to SAMPLE; otherwise decrement.
  - WAIT therefore lasts exactly SETTLE cycles.
- SAMPLE (1 cycle):
  - Compare dut_out with the expected value for idx.
  - On mismatch: err_count+1. If first_err_valid=0, set first_err_vec=idx and first_err_valid=1.
  - If idx==2^IN_W-1, go to DONE; idx is not incremented.
  - Otherwise idx+1, counter reloads SETTLE-1, return to WAIT.
- Timing:
  - Each vector occupies SETTLE+1 cycles.
  - A full sweep takes 2^IN_W*(SETTLE+1) cycles from the start edge until done rises.
  - done is registered, high the cycle after the final SAMPLE.
- DONE:
  - done=1; results and dut_in (=last vector) held until start or reset.
  - pass is combinational from done and err_count.
- abort=1 in WAIT or SAMPLE:
  - next state IDLE; done stays 0; idx=0.
  - err_count and first_err fields keep their partial values.
  - The SAMPLE update is suppressed in an aborted SAMPLE cycle.
  - abort has priority over start; abort in IDLE/DONE is ignored.
- start while busy is ignored.
- err_count width IN_W+1 holds the all-fail case (2^IN_W) without wrap.
- X/Z on dut_out counts as a mismatch (use `!==`).

Test Plan:
- Nand DUT, IN_W=2, OUT_W=1, SETTLE=1, expect_table=4'b0111, pulse start -> dut_in steps 0,1,2,3 every 2 cycles; done rises 8 cycles after start edge; err_count=0, pass=1, first_err_valid=0.
- Same, expect_table=4'b1111 (wrong for idx 3) -> err_count=1, first_err_vec=3, first_err_valid=1, pass=0.
- expect_table=4'b1000 (all wrong) -> err_count=4 (no wrap), first_err_vec=0, pass=0.
- SETTLE=3, Nand -> dut_in changes every 4 cycles; done 16 cycles after start; start re-pulsed in DONE clears counters and repeats with identical results.
- Pulse start; assert abort during vector 2 WAIT -> IDLE next cycle, done=0, err_count reflects vectors 0-1 only; start during busy shows no effect.
- Assert reset in SAMPLE of vector 1 with a pending mismatch -> next cycle state IDLE, all outputs 0, and the mismatch is not counted.
